// File: rtl/pc_sequencer_if.sv
// Fetch and decode handshake bundle between pc_sequencer, instruction memory and decode.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic [31:0]       instr;
    logic              stall;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output instr_valid,
        output instr,
        input  stall
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  instr_valid,
        input  instr,
        output stall
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: owns pc, runs the instruction-fetch handshake and selects the next pc.
// Define PCSEQ_MISALIGN_TRAP_EN to trap misaligned jr targets (adds the misalign_err output).
module pc_sequencer #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(32'h0000_0080)
) (
    input  logic              clk,
    input  logic              rst,
    pc_sequencer_if.master    bus,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              branch_taken,
    input  logic [15:0]       branch_off,
    input  logic              jump,
    input  logic [25:0]       jump_tgt,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_addr,
    input  logic              exception,
    input  logic              halt,
    output logic              halted,
`ifdef PCSEQ_MISALIGN_TRAP_EN
    output logic              misalign_err,
`endif
    output logic [31:0]       retired
);

    typedef enum logic [1:0] {StBoot, StFetch, StIssue, StHalted} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       retired_q, retired_d;
    logic              skip_q, skip_d;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] branch_disp;
    logic              fetch_req;
    logic              take;

    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign jr_target   = jr_addr & ~ADDR_W'(3);
    assign branch_disp = {{(ADDR_W-18){branch_off[15]}}, branch_off, 2'b00};
    // skip_q suppresses the request for the one cycle after an exception abandons a fetch
    assign fetch_req   = (state_q == StFetch) && !skip_q;
    assign take        = (state_q == StIssue) && !exception && !bus.stall;

`ifdef PCSEQ_MISALIGN_TRAP_EN
    logic jr_misaligned;
    logic misalign_q;

    assign jr_misaligned = jr && (jr_addr[1:0] != 2'b00);
    assign misalign_err  = misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= take && jr_misaligned;
        end
    end
`endif

    // Redirect priority below exception: jr > jump > branch > sequential
    always_comb begin
        next_pc = pc_plus4;
        if (jr) begin
`ifdef PCSEQ_MISALIGN_TRAP_EN
            next_pc = jr_misaligned ? EXC_VEC : jr_target;
`else
            next_pc = jr_target;
`endif
        end else if (jump) begin
            next_pc = {pc_plus4[ADDR_W-1:28], jump_tgt, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_disp;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        skip_d    = 1'b0;
        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
                if (exception) begin
                    pc_d   = EXC_VEC;
                    skip_d = 1'b1;
                end
            end
            StFetch: begin
                if (exception) begin
                    pc_d   = EXC_VEC;
                    skip_d = 1'b1;
                end else if (fetch_req && bus.imem_ready) begin
                    instr_d = bus.imem_rdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (exception) begin
                    pc_d    = EXC_VEC;
                    state_d = StFetch;
                end else if (!bus.stall) begin
                    retired_d = retired_q + 32'd1;
                    pc_d      = next_pc;
                    state_d   = halt ? StHalted : StFetch;
                end
            end
            StHalted: begin
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StBoot;
            pc_q      <= RESET_VEC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            skip_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            skip_q    <= skip_d;
        end
    end

    assign bus.imem_req    = fetch_req;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = (state_q == StIssue);
    assign bus.instr       = instr_q;
    assign pc              = pc_q;
    assign halted          = (state_q == StHalted);
    assign retired         = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer; the driver plays memory and decode and
// queues expected fetch addresses and issued instructions for an independent monitor.
module tb_pc_sequencer;

    localparam logic [31:0] ResetVec = 32'h0000_0000;
    localparam logic [31:0] ExcVec   = 32'h0000_0080;

    typedef struct packed {
        logic        exc;
        logic        jr;
        logic        jump;
        logic        br;
        logic        halt;
        logic [31:0] jr_addr;
        logic [25:0] jump_tgt;
        logic [15:0] off;
    } redir_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] ret;
    } issue_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic [15:0] branch_off;
    logic        jump;
    logic [25:0] jump_tgt;
    logic        jr;
    logic [31:0] jr_addr;
    logic        exception;
    logic        halt;
    logic        halted;
    logic [31:0] retired;
`ifdef PCSEQ_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W   (32),
        .RESET_VEC(ResetVec),
        .EXC_VEC  (ExcVec)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch_taken(branch_taken),
        .branch_off  (branch_off),
        .jump        (jump),
        .jump_tgt    (jump_tgt),
        .jr          (jr),
        .jr_addr     (jr_addr),
        .exception   (exception),
        .halt        (halt),
        .halted      (halted),
`ifdef PCSEQ_MISALIGN_TRAP_EN
        .misalign_err(misalign_err),
`endif
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_fetch[$];
    issue_t      exp_instr[$];
    logic [31:0] pc_m;
    logic [31:0] retired_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event-missing expected event", name);
    endtask

    // Architectural next-pc rule for an accepted instruction at address cur
    function automatic logic [31:0] model_next(input logic [31:0] cur, input redir_t r);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (r.exc) return ExcVec;
        if (r.jr) begin
`ifdef PCSEQ_MISALIGN_TRAP_EN
            if (r.jr_addr % 4 != 0) return ExcVec;
`endif
            return r.jr_addr - (r.jr_addr % 4);
        end
        if (r.jump) return {seq[31:28], r.jump_tgt, 2'b00};
        if (r.br) return seq + 32'(int'($signed(r.off)) * 4);
        return seq;
    endfunction

    function automatic redir_t rand_redir(input bit allow_exc);
        redir_t r;
        r.exc      = allow_exc && ($urandom_range(0, 9) == 0);
        r.jr       = ($urandom_range(0, 3) == 0);
        r.jump     = ($urandom_range(0, 3) == 0);
        r.br       = ($urandom_range(0, 2) == 0);
        r.halt     = 1'b0;
        r.jr_addr  = $urandom;
        r.jump_tgt = 26'($urandom);
        r.off      = 16'($urandom);
        return r;
    endfunction

    task automatic drive_redir(input redir_t r);
        exception    = r.exc;
        jr           = r.jr;
        jump         = r.jump;
        branch_taken = r.br;
        halt         = r.halt;
        jr_addr      = r.jr_addr;
        jump_tgt     = r.jump_tgt;
        branch_off   = r.off;
    endtask

    // Redirects and halt that the sequencer must ignore in the current phase
    task automatic drive_noise();
        redir_t r;
        r      = rand_redir(1'b0);
        r.halt = 1'($urandom_range(0, 1));
        drive_redir(r);
    endtask

    task automatic wait_req(output bit ok);
        int n;
        n = 0;
        while (!bus.imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = bus.imem_req;
        if (!ok) fail_now("fetch_timeout");
    endtask

    task automatic run_instr(input int wait_cyc, input int stall_cyc, input redir_t r);
        bit          ok;
        logic [31:0] word;
        wait_req(ok);
        if (!ok) return;
        for (int i = 0; i < wait_cyc; i++) begin
            bus.imem_ready = 1'b0;
            drive_noise();
            @(negedge clk);
        end
        drive_redir('0);
        word           = $urandom;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        exp_instr.push_back('{word: word, ret: retired_m});
        @(negedge clk);
        bus.imem_ready = 1'b0;
        for (int i = 0; i < stall_cyc; i++) begin
            check("instr_hold", bus.instr, word);
            check("pc_hold", pc, pc_m);
            bus.stall      = 1'b1;
            bus.imem_ready = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            drive_noise();
            @(negedge clk);
        end
        bus.imem_ready = 1'b0;
        bus.stall      = r.exc ? 1'($urandom_range(0, 1)) : 1'b0;
        drive_redir(r);
        pc_m = model_next(pc_m, r);
        if (!r.exc) retired_m++;
        if (r.exc || !r.halt) exp_fetch.push_back(pc_m);
        @(negedge clk);
`ifdef PCSEQ_MISALIGN_TRAP_EN
        check("misalign_err", 32'(misalign_err), 32'(!r.exc && r.jr && (r.jr_addr % 4 != 0)));
`endif
        bus.stall = 1'b0;
        drive_redir('0);
    endtask

    // Exception while the fetch is outstanding; ready during the dead cycle must be ignored
    task automatic exc_fetch(input int wait_cyc);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        for (int i = 0; i < wait_cyc; i++) begin
            bus.imem_ready = 1'b0;
            drive_noise();
            @(negedge clk);
        end
        drive_redir('0);
        exception = 1'b1;
        pc_m      = ExcVec;
        exp_fetch.push_back(ExcVec);
        @(negedge clk);
        exception      = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_ready = 1'b0;
    endtask

    // Monitor: compare on the first cycle of every fetch request and every issue
    initial begin
        logic [31:0] e;
        issue_t      it;
        bit          prev_req;
        bit          prev_valid;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req   = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (bus.imem_req && !prev_req) begin
                    if (exp_fetch.size() == 0) begin
                        fail_now("unexpected_fetch");
                    end else begin
                        e = exp_fetch.pop_front();
                        check("fetch_addr", bus.imem_addr, e);
                        check("pc", pc, e);
                        check("pc_plus4", pc_plus4, e + 32'd4);
                    end
                end
                if (bus.instr_valid && !prev_valid) begin
                    if (exp_instr.size() == 0) begin
                        fail_now("unexpected_issue");
                    end else begin
                        it = exp_instr.pop_front();
                        check("instr", bus.instr, it.word);
                        check("retired_at_issue", retired, it.ret);
                    end
                end
                prev_req   = bus.imem_req;
                prev_valid = bus.instr_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        redir_t r;
        rst            = 1'b1;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.stall      = 1'b0;
        drive_redir('0);
        pc_m      = ResetVec;
        retired_m = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_pc", pc, ResetVec);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        exp_fetch.push_back(ResetVec);
        rst = 1'b0;

        // Sequential flow; second instruction waits 3 cycles on memory and stalls twice
        run_instr(0, 0, '0);
        run_instr(3, 2, '0);
        run_instr(0, 0, '0);
        check("retired_after_3", retired, 32'd3);

        // Branch backwards from 0x100, then jump beats branch from 0x1000_003C
        r = '0; r.jr = 1'b1; r.jr_addr = 32'h0000_0100;
        run_instr(0, 0, r);
        r = '0; r.br = 1'b1; r.off = 16'hFFFC;
        run_instr(1, 0, r);
        r = '0; r.jr = 1'b1; r.jr_addr = 32'h1000_003C;
        run_instr(0, 0, r);
        r = '0; r.jump = 1'b1; r.br = 1'b1; r.jump_tgt = 26'h000_0010; r.off = 16'h0100;
        run_instr(0, 1, r);

        exc_fetch(2);
        run_instr(0, 0, '0);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                exc_fetch($urandom_range(0, 3));
            end else begin
                run_instr($urandom_range(0, 3), $urandom_range(0, 2), rand_redir(1'b1));
            end
        end

        r = '0; r.halt = 1'b1;
        run_instr(0, 0, r);
        for (int i = 0; i < 20; i++) begin
            check("halted", 32'(halted), 32'd1);
            check("halt_req", 32'(bus.imem_req), 32'd0);
            bus.imem_ready = 1'($urandom_range(0, 1));
            drive_noise();
            @(negedge clk);
        end
        drive_redir('0);
        bus.imem_ready = 1'b0;
        check("halt_pc", pc, pc_m);
        check("halt_retired", retired, retired_m);
        check("halt_valid", 32'(bus.instr_valid), 32'd0);

        rst = 1'b1;
        @(negedge clk);
        check("rst2_pc", pc, ResetVec);
        check("rst2_retired", retired, 32'd0);
        check("rst2_halted", 32'(halted), 32'd0);
        pc_m      = ResetVec;
        retired_m = 32'd0;
        exp_fetch.push_back(ResetVec);
        rst = 1'b0;
        run_instr(0, 0, '0);

        r = '0; r.jr = 1'b1; r.jr_addr = 32'h0000_0203;
        run_instr(0, 0, r);
        @(negedge clk);
`ifdef PCSEQ_MISALIGN_TRAP_EN
        check("misalign_pulse_end", 32'(misalign_err), 32'd0);
`endif
        repeat (2) @(negedge clk);
        check("fetch_queue_drained", 32'(exp_fetch.size()), 32'd0);
        check("issue_queue_drained", 32'(exp_instr.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the MIPS_R_US processor. Owns the program counter and the PC+4 adder and runs the instruction-fetch handshake with instruction memory. Chooses the next PC from the sequential, branch, jump, jump-register and exception sources. Sits between the instruction memory port and the decode stage of the processor top level.

Parameters:
ADDR_W, 32, PC and memory address width (minimum 32; jump arithmetic uses bits [31:28])
RESET_VEC, 32'h0000_0000, PC value loaded by reset
EXC_VEC, 32'h0000_0080, PC value loaded on exception

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address; always equals pc
imem_ready  in  1  memory has returned data this cycle
imem_rdata  in  32  instruction word from memory
instr_valid  out  1  instr holds an instruction waiting for decode
instr  out  32  latched instruction
pc  out  ADDR_W  current PC
pc_plus4  out  ADDR_W  pc + 4, combinational
stall  in  1  decode not ready; hold the current instruction
branch_taken  in  1  conditional branch resolved taken
branch_off  in  16  branch immediate, in words
jump  in  1  J/JAL
jump_tgt  in  26  jump index field
jr  in  1  JR/JALR
jr_addr  in  ADDR_W  register target
exception  in  1  synchronous exception request
halt  in  1  stop fetching
halted  out  1  sequencer is in HALTED
retired  out  32  count of instructions accepted by decode

Behaviour:
- Reset (asynchronous): pc=RESET_VEC, state=BOOT, instr=0, instr_valid=0, imem_req=0, retired=0, halted=0.
- States:
  - BOOT: one idle cycle, then FETCH.
  - FETCH: imem_req=1. On imem_ready, latch imem_rdata into instr and go to ISSUE. Wait states are unlimited.
  - ISSUE: instr_valid=1, imem_req=0.
    - stall=1: hold pc, instr and state.
    - stall=0: retired increments by 1 (wraps), pc loads next_pc, state goes to FETCH.
    - stall=0 and halt=1: retired increments, pc loads next_pc, state goes to HALTED.
  - HALTED: halted=1, imem_req=0, instr_valid=0. pc, instr and retired are frozen. Only rst leaves this state.
- next_pc priority (sampled in ISSUE when stall=0): exception > jr > jump > branch_taken > sequential.
  - exception: EXC_VEC
  - jr: {jr_addr[ADDR_W-1:2], 2'b00}
  - jump: {pc_plus4[31:28], jump_tgt, 2'b00}
  - branch: pc_plus4 + (sign_extend(branch_off) << 2)
  - sequential: pc_plus4
- All address arithmetic wraps modulo 2^ADDR_W. No overflow flag.
- Exception in FETCH or BOOT:
  - Any pending fetch is abandoned and the returning data is discarded.
  - pc=EXC_VEC on the next edge.
  - State goes to FETCH with imem_req low for that one cycle.
  - retired does not change.
- exception wins over stall in ISSUE:
  - pc=EXC_VEC, state goes to FETCH, retired does not change.
  - The faulting instruction is not counted.
- Redirect inputs other than exception are ignored outside ISSUE.
- Redirect inputs other than exception are ignored in ISSUE while stall=1.
- imem_ready while imem_req=0 is ignored.
- Latency from a redirect being accepted to imem_req at the new address: 1 cycle.
- Best-case throughput: one instruction every 2 cycles (FETCH with immediate ready, then ISSUE).

Optional Feature:
PCSEQ_MISALIGN_TRAP_EN
- Defined:
  - jr with jr_addr[1:0]!=0 selects EXC_VEC instead of the jump-register target.
  - Adds output misalign_err (1 bit). It is a one-cycle pulse on the edge that takes the redirect, reset value 0.
  - retired still increments.
- Undefined: jr_addr[1:0] is silently cleared and no misalign_err port exists.

Test Plan:
- Reset, then imem_ready=1 every FETCH cycle, stall=0, no redirects -> imem_addr sequence 0x0,0x4,0x8. After 3 ISSUE cycles retired=3.
- imem_ready delayed by 3 cycles; stall=1 for 2 ISSUE cycles -> imem_req held for 4 cycles, pc=0x4 and instr stable throughout, retired increments once.
- pc=0x0000_0100 with branch_taken=1, branch_off=16'hFFFC -> next imem_addr=0x0000_00F4.
- pc=0x1000_0040 with jump=1, branch_taken=1, jump_tgt=26'h0000010 -> jump wins, imem_addr=0x1000_0040.
- exception asserted during FETCH while waiting on imem_ready -> next cycle imem_req=0 with pc=0x80, then fetch from 0x80. Late imem_rdata is not latched and retired is unchanged.
- halt=1 with stall=0 -> halted=1, imem_req stays 0 for 20 cycles. Pulse rst -> pc=0x0, retired=0, BOOT. With PCSEQ_MISALIGN_TRAP_EN defined, jr_addr=0x203 -> pc=0x80 and misalign_err pulses for 1 cycle.
